// File: rtl/rep_output_buf.sv
// rep_output_buf: merges the two per-channel result FIFOs into one paired,
// framed word stream for the downstream sink FIFO.
//
// Pops both channel FIFOs together (read latency 1) and writes each pair to
// the sink two cycles after the read strobe. It adds start/end-of-frame
// markers, counts completed frames, and stops with a sticky error when one
// channel stays non-empty alone for too long.
//
// Ports:
//   clk_i             clock
//   nrst_i            asynchronous active-low reset
//   run_i             enable, registered into r_run before use
//   fifo_empty_i      per-channel FIFO empty flags
//   fifo_data_i       per-channel FIFO read data, valid one cycle after read
//   fifo_rd_o         per-channel read strobes, both bits always equal
//   out_almost_full_i sink almost-full (sink keeps >=3 free words at threshold)
//   out_data_o        paired word, [0]=ch0, [1]=ch1
//   out_wr_o          sink write strobe
//   out_sof_o         first word of a frame, qualified by out_wr_o
//   out_eof_o         last word of a frame, qualified by out_wr_o
//   skew_err_o        sticky channel-skew error, cleared on leaving ERR
//   frame_cnt_o       completed frame count, wraps mod 2^16
module rep_output_buf #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 256,
    parameter int SKEW_MAX  = 4
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    input  logic                   run_i,
    input  logic [1:0]             fifo_empty_i,
    input  logic [1:0][DATA_W-1:0] fifo_data_i,
    output logic [1:0]             fifo_rd_o,
    input  logic                   out_almost_full_i,
    output logic [1:0][DATA_W-1:0] out_data_o,
    output logic                   out_wr_o,
    output logic                   out_sof_o,
    output logic                   out_eof_o,
    output logic                   skew_err_o,
    output logic [15:0]            frame_cnt_o
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SKW_W = $clog2(SKEW_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [SKW_W-1:0] SKW_LIM  = SKW_W'(SKEW_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

    state_t                   r_state;
    logic                     r_run;
    logic                     r_rd_q;
    logic [IDX_W-1:0]         r_idx;
    logic [SKW_W-1:0]         r_skew_cnt;
    logic                     r_skew_err;
    logic [1:0][DATA_W-1:0]   r_data;
    logic                     r_wr;
    logic                     r_sof;
    logic                     r_eof;
    logic [15:0]              r_frame_cnt;

    logic w_rd;
    logic w_skew;
    logic w_last;
    logic w_idle_ok;
    logic w_to_idle;

    // Only read when both channels have data and the sink can absorb the
    // two words that may still be in flight.
    assign w_rd      = (r_state == RUN) && !fifo_empty_i[0] && !fifo_empty_i[1]
                       && !out_almost_full_i;
    assign w_skew    = fifo_empty_i[0] ^ fifo_empty_i[1];
    assign w_last    = (r_idx == IDX_LAST);
    assign w_idle_ok = !r_rd_q && !w_rd;
    assign w_to_idle = ((r_state == DRAIN) && w_idle_ok)
                       || ((r_state == ERR) && !r_run && w_idle_ok);

    assign fifo_rd_o   = {2{w_rd}};
    assign out_data_o  = r_data;
    assign out_wr_o    = r_wr;
    assign out_sof_o   = r_sof;
    assign out_eof_o   = r_eof;
    assign skew_err_o  = r_skew_err;
    assign frame_cnt_o = r_frame_cnt;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state    <= IDLE;
            r_run      <= 1'b0;
            r_rd_q     <= 1'b0;
            r_skew_cnt <= '0;
            r_skew_err <= 1'b0;
        end else begin
            r_run  <= run_i;
            r_rd_q <= w_rd;
            case (r_state)
                IDLE:
                    if (r_run)
                        r_state <= RUN;
                RUN:
                    if (r_skew_cnt == SKW_LIM) begin
                        r_state    <= ERR;
                        r_skew_err <= 1'b1;
                    end else if (!r_run) begin
                        r_state <= DRAIN;
                    end
                DRAIN:
                    if (w_to_idle)
                        r_state <= IDLE;
                ERR:
                    if (w_to_idle) begin
                        r_state    <= IDLE;
                        r_skew_err <= 1'b0;
                    end
                default:
                    r_state <= IDLE;
            endcase
            // Counts consecutive one-sided cycles; any balanced cycle restarts it.
            r_skew_cnt <= (r_state != RUN) ? '0 :
                          !w_skew ? '0 :
                          (r_skew_cnt == SKW_LIM) ? r_skew_cnt :
                          r_skew_cnt + SKW_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_data      <= '0;
            r_wr        <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (r_rd_q) begin
                r_data <= fifo_data_i;
                r_wr   <= 1'b1;
                r_sof  <= (r_idx == '0);
                r_eof  <= w_last;
                r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_last)
                    r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_wr  <= 1'b0;
                r_sof <= 1'b0;
                r_eof <= 1'b0;
            end
            // Entering IDLE never coincides with a write, so a cut-off frame
            // simply restarts at word 0 on the next run.
            if (w_to_idle)
                r_idx <= '0;
        end
    end

endmodule

// File: tb/tb_rep_output_buf.sv
// tb_rep_output_buf: scoreboard bench for rep_output_buf with FRAME_LEN=4.
module tb_rep_output_buf;

    localparam int DW = 12;
    localparam int FL = 4;
    localparam int SM = 4;

    logic              clk = 1'b0;
    logic              nrst_i = 1'b0;
    logic              run_i = 1'b0;
    logic [1:0]        fifo_empty = 2'b11;
    logic [1:0][DW-1:0] fifo_data = '0;
    logic [1:0]        fifo_rd_o;
    logic              almost_full = 1'b0;
    logic [1:0][DW-1:0] out_data_o;
    logic              out_wr_o;
    logic              out_sof_o;
    logic              out_eof_o;
    logic              skew_err_o;
    logic [15:0]       frame_cnt_o;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int exp_frames = 0;
    int midx = 0;

    logic [DW-1:0]     q0[$];
    logic [DW-1:0]     q1[$];
    logic [2*DW+1:0]   sb[$];
    logic [2*DW+1:0]   e;

    rep_output_buf #(.DATA_W(DW), .FRAME_LEN(FL), .SKEW_MAX(SM)) dut (
        .clk_i(clk),
        .nrst_i(nrst_i),
        .run_i(run_i),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data),
        .fifo_rd_o(fifo_rd_o),
        .out_almost_full_i(almost_full),
        .out_data_o(out_data_o),
        .out_wr_o(out_wr_o),
        .out_sof_o(out_sof_o),
        .out_eof_o(out_eof_o),
        .skew_err_o(skew_err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    // Source FIFO model: read data one cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_o[0]) fifo_data[0] <= q0.pop_front();
        if (fifo_rd_o[1]) fifo_data[1] <= q1.pop_front();
        fifo_empty <= {q1.size() == 0, q0.size() == 0};
    end

    // Sink-side scoreboard.
    always @(negedge clk) begin
        if (nrst_i) begin
            if (out_wr_o) begin
                wr_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got=%h", {out_data_o, out_sof_o, out_eof_o});
                end else begin
                    e = sb.pop_front();
                    if ({out_data_o, out_sof_o, out_eof_o} !== e) begin
                        errors++;
                        $display("FAIL word {data,sof,eof} got=%h exp=%h", {out_data_o, out_sof_o, out_eof_o}, e);
                    end
                    if (e[0]) exp_frames++;
                end
                checks++;
                if (frame_cnt_o !== 16'(exp_frames)) begin
                    errors++;
                    $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_frames);
                end
            end else begin
                checks++;
                if ({out_sof_o, out_eof_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL marker_without_write got=%b exp=00", {out_sof_o, out_eof_o});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        q0.push_back(a);
        q1.push_back(b);
        sb.push_back({b, a, midx == 0, midx == FL - 1});
        midx = (midx + 1) % FL;
    endtask

    task automatic stop_run;
        run_i = 1'b0;
        repeat (8) @(negedge clk);
        midx = 0;
    endtask

    task automatic test_reset;
        nrst_i = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (fifo_rd_o !== 2'b00) begin errors++; $display("FAIL rst_rd got=%b exp=00", fifo_rd_o); end
        if (out_wr_o !== 1'b0) begin errors++; $display("FAIL rst_wr got=%b exp=0", out_wr_o); end
        if (out_data_o !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", out_data_o); end
        if (out_sof_o !== 1'b0) begin errors++; $display("FAIL rst_sof got=%b exp=0", out_sof_o); end
        if (out_eof_o !== 1'b0) begin errors++; $display("FAIL rst_eof got=%b exp=0", out_eof_o); end
        if (skew_err_o !== 1'b0) begin errors++; $display("FAIL rst_skew got=%b exp=0", skew_err_o); end
        if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_frame got=%0d exp=0", frame_cnt_o); end
        nrst_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [1:0] exp_rd;
        logic       exp_wr;
        midx = 0;
        push_pair(12'h001, 12'h101);
        push_pair(12'h002, 12'h102);
        push_pair(12'h003, 12'h103);
        repeat (2) @(negedge clk);
        run_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            #1;
            exp_rd = (i >= 2 && i <= 4) ? 2'b11 : 2'b00;
            exp_wr = (i >= 4 && i <= 6);
            checks += 2;
            if (fifo_rd_o !== exp_rd) begin errors++; $display("FAIL basic_rd cyc=%0d got=%b exp=%b", i, fifo_rd_o, exp_rd); end
            if (out_wr_o !== exp_wr) begin errors++; $display("FAIL basic_wr cyc=%0d got=%b exp=%b", i, out_wr_o, exp_wr); end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL basic_left got=%0d exp=0", sb.size()); end
        stop_run();
        checks++;
        if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL basic_frame got=%0d exp=0", frame_cnt_o); end
    endtask

    task automatic test_frame;
        for (int i = 0; i < 9; i++) push_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        run_i = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin @(negedge clk); #1; end
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL frame_left got=%0d exp=0", sb.size()); end
        if (frame_cnt_o !== 16'd2) begin errors++; $display("FAIL frame_total got=%0d exp=2", frame_cnt_o); end
        stop_run();
    endtask

    task automatic test_almost_full;
        int w0;
        for (int i = 0; i < 10; i++) push_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        run_i = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        almost_full = 1'b1;
        #1;
        w0 = wr_cnt;
        checks++;
        if (fifo_rd_o !== 2'b00) begin errors++; $display("FAIL af_rd_drop got=%b exp=00", fifo_rd_o); end
        repeat (6) @(negedge clk);
        #1;
        checks += 2;
        if (wr_cnt - w0 > 2) begin errors++; $display("FAIL af_extra_writes got=%0d exp<=2", wr_cnt - w0); end
        if (fifo_rd_o !== 2'b00) begin errors++; $display("FAIL af_rd_hold got=%b exp=00", fifo_rd_o); end
        almost_full = 1'b0;
        #1;
        checks++;
        if (fifo_rd_o !== 2'b11) begin errors++; $display("FAIL af_resume got=%b exp=11", fifo_rd_o); end
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin @(negedge clk); #1; end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL af_left got=%0d exp=0", sb.size()); end
        stop_run();
    endtask

    task automatic test_skew;
        int  n;
        logic rd_seen;
        run_i = 1'b1;
        repeat (3) @(negedge clk);
        q0.push_back(12'h5A5);
        n = 0;
        rd_seen = 1'b0;
        while (n < 12 && skew_err_o !== 1'b1) begin
            @(negedge clk);
            #1;
            n++;
            if (fifo_rd_o != 2'b00) rd_seen = 1'b1;
        end
        checks += 3;
        if (skew_err_o !== 1'b1) begin errors++; $display("FAIL skew_set got=%b exp=1", skew_err_o); end
        if (n != SM + 2) begin errors++; $display("FAIL skew_latency got=%0d exp=%0d", n, SM + 2); end
        if (rd_seen) begin errors++; $display("FAIL skew_read got=1 exp=0"); end
        q1.push_back(12'h3C3);
        sb.push_back({12'h3C3, 12'h5A5, midx == 0, midx == FL - 1});
        midx = (midx + 1) % FL;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks += 2;
            if (fifo_rd_o !== 2'b00) begin errors++; $display("FAIL err_no_read got=%b exp=00", fifo_rd_o); end
            if (skew_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", skew_err_o); end
        end
        run_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (skew_err_o !== 1'b0) begin errors++; $display("FAIL skew_clear got=%b exp=0", skew_err_o); end
        run_i = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(negedge clk); #1; end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL skew_pair_left got=%0d exp=0", sb.size()); end
        q0.push_back(12'h0AA);
        repeat (3) @(negedge clk);
        q1.push_back(12'h0BB);
        sb.push_back({12'h0BB, 12'h0AA, midx == 0, midx == FL - 1});
        midx = (midx + 1) % FL;
        rd_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (skew_err_o !== 1'b0) rd_seen = 1'b1;
        end
        checks += 2;
        if (rd_seen) begin errors++; $display("FAIL gap3_err got=1 exp=0"); end
        if (sb.size() != 0) begin errors++; $display("FAIL gap3_left got=%0d exp=0", sb.size()); end
        stop_run();
    endtask

    task automatic test_run_drop;
        logic [15:0] f0;
        logic [1:0]  exp_rd;
        f0 = frame_cnt_o;
        for (int i = 0; i < 3; i++) push_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        midx = 0;
        for (int i = 0; i < 2; i++) push_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        repeat (2) @(negedge clk);
        run_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            if (i == 3) run_i = 1'b0;
            exp_rd = (i >= 2 && i <= 4) ? 2'b11 : 2'b00;
            checks++;
            if (fifo_rd_o !== exp_rd) begin errors++; $display("FAIL drop_rd cyc=%0d got=%b exp=%b", i, fifo_rd_o, exp_rd); end
        end
        checks += 2;
        if (sb.size() != 2) begin errors++; $display("FAIL drop_inflight_left got=%0d exp=2", sb.size()); end
        if (frame_cnt_o !== f0) begin errors++; $display("FAIL drop_frame got=%0d exp=%0d", frame_cnt_o, f0); end
        run_i = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(negedge clk); #1; end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drop_restart_left got=%0d exp=0", sb.size()); end
        stop_run();
    endtask

    task automatic test_reset_mid;
        int  w0;
        bit  hit;
        for (int i = 0; i < 6; i++) push_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        run_i = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = (out_wr_o === 1'b1);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_no_write got=0 exp=1"); end
        nrst_i = 1'b0;
        #1;
        checks += 6;
        if (fifo_rd_o !== 2'b00) begin errors++; $display("FAIL rstmid_rd got=%b exp=00", fifo_rd_o); end
        if (out_wr_o !== 1'b0) begin errors++; $display("FAIL rstmid_wr got=%b exp=0", out_wr_o); end
        if (out_data_o !== '0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", out_data_o); end
        if ({out_sof_o, out_eof_o} !== 2'b00) begin errors++; $display("FAIL rstmid_marks got=%b exp=00", {out_sof_o, out_eof_o}); end
        if (skew_err_o !== 1'b0) begin errors++; $display("FAIL rstmid_skew got=%b exp=0", skew_err_o); end
        if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_frame got=%0d exp=0", frame_cnt_o); end
        q0.delete();
        q1.delete();
        sb.delete();
        exp_frames = 0;
        midx = 0;
        repeat (2) @(negedge clk);
        nrst_i = 1'b1;
        #1;
        w0 = wr_cnt;
        repeat (8) @(negedge clk);
        #1;
        checks += 2;
        if (wr_cnt != w0) begin errors++; $display("FAIL rstmid_spurious got=%0d exp=0", wr_cnt - w0); end
        if (fifo_rd_o !== 2'b00) begin errors++; $display("FAIL rstmid_idle_rd got=%b exp=00", fifo_rd_o); end
        push_pair(12'h7E7, 12'h181);
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(negedge clk); #1; end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rstmid_after_left got=%0d exp=0", sb.size()); end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_almost_full();
        test_skew();
        test_run_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rep_output_buf.md
Name: rep_output_buf

Overview:
Merge stage at the tail of the dual-channel path. It pops the two per-channel result FIFOs together, with read latency 1, and re-joins them into one paired word stream for the downstream sink FIFO. It adds frame markers and a frame counter, and flags persistent inter-channel skew. Downstream backpressure is honoured through an almost-full input.

Parameters:
DATA_W, 12, width of one channel sample
FRAME_LEN, 256, paired words per frame (>=1)
SKEW_MAX, 4, consecutive one-sided-non-empty cycles before skew error (>=1)

Ports:
clk_i  input  1  clock
nrst_i  input  1  asynchronous, active-low reset
run_i  input  1  enable; sampled into run_r, one-cycle latency
fifo_empty_i  input  2  per-channel FIFO empty flags
fifo_data_i  input  2xDATA_W  per-channel FIFO read data; valid 1 cycle after read
fifo_rd_o  output  2  per-channel FIFO read strobes; both bits always equal
out_almost_full_i  input  1  sink FIFO almost-full; sink threshold leaves >=3 free words
out_data_o  output  2xDATA_W  paired word: [0]=ch0, [1]=ch1
out_wr_o  output  1  sink write strobe
out_sof_o  output  1  first word of frame, qualified by out_wr_o
out_eof_o  output  1  last word of frame, qualified by out_wr_o
skew_err_o  output  1  sticky channel-skew error
frame_cnt_o  output  16  completed frames, wraps mod 2^16

Behaviour:
- Reset values: fifo_rd_o=0, out_wr_o=0, out_data_o=0, out_sof_o=0, out_eof_o=0, skew_err_o=0, frame_cnt_o=0.
- Internal reset values: run_r=0, state=IDLE, idx=0, skew counter=0, pipeline flags=0.
- Reset mid-operation: all of the above are cleared immediately; in-flight reads are discarded.
- FSM states: IDLE, RUN, DRAIN, ERR.
- IDLE -> RUN when run_r=1. On entry to IDLE, idx is cleared to 0.
- RUN -> DRAIN when run_r=0.
- RUN -> ERR when the skew counter reaches SKEW_MAX.
- DRAIN -> IDLE when no read is in flight (rd_q=0 and the read strobe is low).
- ERR -> IDLE when run_r=0 and no read is in flight.
- fifo_rd_o, both bits, is combinational from registered state: state==RUN && !fifo_empty_i[0] && !fifo_empty_i[1] && !out_almost_full_i.
  - Reads can therefore be back-to-back, one pair per cycle, with no underflow.
  - A read is never issued to only one FIFO.
- Pipeline: rd_q <= fifo_rd_o[0]. When rd_q=1, out_data_o <= fifo_data_i and out_wr_o <= 1; otherwise out_wr_o <= 0 and out_data_o holds its value.
  - Latency from read strobe to sink write is 2 cycles.
  - Up to 2 words are in flight after almost-full asserts, which is why the sink threshold must leave >=3 free words.
- Reads in flight when the FSM leaves RUN, whether to DRAIN or to ERR, complete and are written out. No read data is lost.
- Framing: out_sof_o <= (idx==0) and out_eof_o <= (idx==FRAME_LEN-1), both registered together with the word. Both are 0 whenever out_wr_o=0.
  - Each written word advances idx by 1, wrapping to 0 after FRAME_LEN-1.
  - FRAME_LEN=1: every word carries sof=1 and eof=1.
- frame_cnt_o increments on each written word with eof=1, wrapping 0xFFFF -> 0. Only reset clears it.
- A partial frame cut off by run deassert produces no eof and is not counted. The next run restarts at idx=0 with sof.
- Skew counter, in RUN only:
  - Increments each cycle where fifo_empty_i[0] != fifo_empty_i[1].
  - Clears to 0 on any cycle where the flags are equal.
  - Saturates at SKEW_MAX.
  - Holds 0 outside RUN.
- skew_err_o is set on entry to ERR. It stays set until the FSM returns from ERR to IDLE, clearing on that transition.
- While in ERR, no reads are issued.

Test Plan:
- Reset then run_i=1 with 3 pairs preloaded (ch0 0x001..0x003, ch1 0x101..0x103), sink not full -> fifo_rd_o=2'b11 for 3 consecutive cycles starting 2 cycles after run_i rises; out_wr_o pulses 3 cycles, each 2 cycles after its read; out_data_o={0x101,0x001},{0x102,0x002},{0x103,0x003}; first word sof=1.
- FRAME_LEN=4, 9 pairs streamed -> sof on words 0, 4, 8; eof on words 3 and 7; frame_cnt_o goes 0->1->2; word 8 has eof=0.
- out_almost_full_i asserted mid-stream -> fifo_rd_o drops the same cycle; at most 2 further out_wr_o pulses; streaming resumes the cycle after deassert with no word lost or duplicated.
- ch0 non-empty and ch1 empty for SKEW_MAX=4 cycles in RUN -> ERR; skew_err_o=1; no reads. Then run_i=0 -> IDLE and skew_err_o=0. A 3-cycle one-sided gap -> no error.
- run_i dropped mid-frame (idx=2) with a read in flight -> that word is still written with correct data; FSM passes through DRAIN to IDLE; the next run's first word has sof=1; frame_cnt_o unchanged.
- nrst_i asserted while out_wr_o=1 and a read is in flight -> all outputs 0 immediately; frame_cnt_o=0; after release, no write occurs until run_r=1 and both FIFOs are non-empty.
